x_mux_sweep_ctrl: RTL and testbench

- Sequencer for the trigger mux select word.
- On a start command, walks the select word from a first value to a last value, one step at a time.
- At each step it waits a settle interval, then counts delay-line hit cycles over a programmable dwell window, then hands the (select, count) result to a downstream consumer over a valid/ready handshake.
- Sits between the host/calibration logic and x_mux_trigger; drives that block's select input.

---
 rtl/x_mux_pkg.sv | 17 +
 rtl/x_mux_hit_cnt.sv | 25 ++
 rtl/x_mux_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_x_mux_sweep_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_mux_pkg.sv
// rtl/x_mux_pkg.sv - shared types and default sizes for the trigger mux sweep controller
package x_mux_pkg;

   localparam int WIDTH_DEF      = 32;
   localparam int DWELL_W_DEF    = 16;
   localparam int CNT_W_DEF      = 16;
   localparam int SETTLE_CYC_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_DWELL  = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/x_mux_hit_cnt.sv
// rtl/x_mux_hit_cnt.sv - saturating delay-line hit counter with synchronous clear
module x_mux_hit_cnt
   import x_mux_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_hit,
   output logic [CNT_W-1:0] o_cnt
);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_cnt <= '0;
      end else if (i_clr) begin
         o_cnt <= '0;
      end else if (i_en && i_hit && (o_cnt != {CNT_W{1'b1}})) begin
         o_cnt <= o_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/x_mux_sweep_ctrl.sv
// rtl/x_mux_sweep_ctrl.sv - steps the trigger mux select word and reports per-step hit counts
module x_mux_sweep_ctrl
   import x_mux_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int DWELL_W    = DWELL_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [WIDTH-1:0]   i_first,
   input  logic [WIDTH-1:0]   i_last,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic               i_hit,
   output logic [WIDTH-1:0]   o_sel,
   output logic               o_busy,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic [WIDTH-1:0]   o_res_sel,
   output logic [CNT_W-1:0]   o_res_cnt,
   output logic               o_done
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_SETTLE = ST_SETTLE;
   localparam logic [2:0] S_DWELL  = ST_DWELL;
   localparam logic [2:0] S_REPORT = ST_REPORT;
   localparam logic [2:0] S_DONE   = ST_DONE;

   localparam int               SET_W    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic [WIDTH-1:0]   last_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_last;
   logic [DWELL_W-1:0] dwell_ctr;
   logic [SET_W-1:0]   settle_ctr;
   logic               settle_end;
   logic               dwell_end;
   logic               start_ok;
   logic               accept;

   // A zero dwell still gets one counting cycle.
   assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
   assign settle_end = (settle_ctr == SET_LAST);
   assign dwell_end  = (dwell_ctr == dwell_last);
   assign start_ok   = (state == S_IDLE) && i_start && (i_first <= i_last);
   assign accept     = (state == S_REPORT) && i_res_ready && !i_abort;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (i_start) state_nx = (i_first <= i_last) ? S_SETTLE : S_DONE;
         S_SETTLE: if (settle_end) state_nx = S_DWELL;
         S_DWELL:  if (dwell_end) state_nx = S_REPORT;
         S_REPORT: if (i_res_ready) state_nx = (o_sel == last_q) ? S_DONE : S_SETTLE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      // Abort wins over everything except a start seen in IDLE.
      if (i_abort && (state != S_IDLE)) state_nx = S_IDLE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_IDLE;
         o_busy      <= 1'b0;
         o_res_valid <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         state       <= state_nx;
         o_busy      <= (state_nx != S_IDLE);
         o_res_valid <= (state_nx == S_REPORT);
         o_done      <= (state_nx == S_DONE);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_q  <= '0;
         dwell_q <= '0;
         o_sel   <= '0;
      end else if (start_ok) begin
         last_q  <= i_last;
         dwell_q <= i_dwell;
         o_sel   <= i_first;
      end else if (accept && (o_sel != last_q)) begin
         o_sel <= o_sel + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         settle_ctr <= '0;
         dwell_ctr  <= '0;
      end else begin
         settle_ctr <= (state == S_SETTLE) ? settle_ctr + SET_W'(1) : '0;
         dwell_ctr  <= (state == S_DWELL) ? dwell_ctr + DWELL_W'(1) : '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_res_sel <= '0;
      end else if ((state == S_DWELL) && dwell_end) begin
         o_res_sel <= o_sel;
      end
   end

   // The counter is frozen outside DWELL, so its value is the REPORT payload.
   x_mux_hit_cnt #(
      .CNT_W (CNT_W)
   ) u_hit_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr ((state == S_SETTLE) && settle_end),
      .i_en  (state == S_DWELL),
      .i_hit (i_hit),
      .o_cnt (o_res_cnt)
   );

endmodule

// File: tb/tb_x_mux_sweep_ctrl.sv
// tb/tb_x_mux_sweep_ctrl.sv - randomized scoreboard bench for the mux sweep controller
module tb_x_mux_sweep_ctrl;

   localparam int S = 2;

   logic        i_clk;
   logic        i_rst;
   logic        i_start, i_abort, i_hit, i_res_ready;
   logic [31:0] i_first, i_last;
   logic [15:0] i_dwell;
   logic [31:0] o_sel, o_res_sel;
   logic [15:0] o_res_cnt;
   logic        o_busy, o_res_valid, o_done;

   logic        s_start, s_hit, s_ready;
   logic [7:0]  s_first, s_last, s_dwell, s_sel, s_res_sel;
   logic [1:0]  s_res_cnt;
   logic        s_busy, s_valid, s_done;

   typedef struct {
      logic [31:0] sel;
      logic [15:0] cnt;
   } res_t;

   res_t exp_q[$];
   logic        exp_busy, exp_valid, exp_done;
   logic [31:0] exp_sel;
   bit          chk_en;
   int          vectors, errors;
   int          ab_at, rs_at;

   x_mux_sweep_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .i_first(i_first), .i_last(i_last), .i_dwell(i_dwell), .i_hit(i_hit),
      .o_sel(o_sel), .o_busy(o_busy), .o_res_valid(o_res_valid),
      .i_res_ready(i_res_ready), .o_res_sel(o_res_sel), .o_res_cnt(o_res_cnt),
      .o_done(o_done)
   );

   x_mux_sweep_ctrl #(.WIDTH(8), .DWELL_W(8), .CNT_W(2), .SETTLE_CYC(1)) dut_sat (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(s_start), .i_abort(1'b0),
      .i_first(s_first), .i_last(s_last), .i_dwell(s_dwell), .i_hit(s_hit),
      .o_sel(s_sel), .o_busy(s_busy), .o_res_valid(s_valid),
      .i_res_ready(s_ready), .o_res_sel(s_res_sel), .o_res_cnt(s_res_cnt),
      .o_done(s_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: per-cycle control checks plus scoreboard payload checks.
   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("busy", 64'(o_busy), 64'(exp_busy));
         chk("res_valid", 64'(o_res_valid), 64'(exp_valid));
         chk("done", 64'(o_done), 64'(exp_done));
         chk("sel", 64'(o_sel), 64'(exp_sel));
         if (o_res_valid) begin
            if (exp_q.size() == 0) begin
               chk("res_unexpected", 64'(1), 64'(0));
            end else begin
               chk("res_sel", 64'(o_res_sel), 64'(exp_q[0].sel));
               chk("res_cnt", 64'(o_res_cnt), 64'(exp_q[0].cnt));
               if (i_res_ready && !i_abort) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic gen_hit(input int hm, input int p);
      if (hm == 1) return 1'b1;
      if (hm == 2) return 1'(p % 2);
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic gen_rdy(input int rm, input int n);
      if (rm == 0) return 1'b1;
      if (rm == 2) return (n >= 3);
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic brk(input int p, output bit stop);
      stop = 1'b0;
      if (p == ab_at) begin
         i_abort = 1'b1;
         tick();
         i_abort = 1'b0; i_start = 1'b0; i_res_ready = 1'b0;
         exp_busy = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
         exp_q.delete();
         stop = 1'b1;
      end else if (p == rs_at) begin
         #1;
         i_rst = 1'b1;
         exp_busy = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_sel = '0;
         exp_q.delete();
         #1;
         chk("rst_sel", 64'(o_sel), 64'(0));
         chk("rst_busy", 64'(o_busy), 64'(0));
         chk("rst_valid", 64'(o_res_valid), 64'(0));
         chk("rst_res_sel", 64'(o_res_sel), 64'(0));
         chk("rst_res_cnt", 64'(o_res_cnt), 64'(0));
         chk("rst_done", 64'(o_done), 64'(0));
         tick();
         i_rst = 1'b0; i_start = 1'b0; i_res_ready = 1'b0;
         stop = 1'b1;
      end
   endtask

   // Reference: settle S cycles, dwell max(d,1) cycles counting hits, report until accepted.
   task automatic run_sweep(input logic [31:0] first, input logic [31:0] last,
                            input logic [15:0] dwell, input int hm, input int rm,
                            input int ab_p, input int rs_p, input bit sa);
      int p, dl, nr;
      logic [31:0] cur;
      logic [15:0] cnt;
      bit stop, acc;
      ab_at = ab_p; rs_at = rs_p;
      i_first = first; i_last = last; i_dwell = dwell;
      i_start = 1'b1; i_abort = sa;
      tick();
      i_start = 1'b0; i_abort = 1'b0; p = 1;
      if (first > last) begin
         exp_busy = 1'b1; exp_done = 1'b1;
         tick();
         exp_busy = 1'b0; exp_done = 1'b0;
         return;
      end
      dl = (dwell == 0) ? 1 : int'(dwell);
      cur = first; exp_sel = first; exp_busy = 1'b1;
      forever begin
         for (int s = 0; s < S; s++) begin
            i_hit = gen_hit(hm, p); i_start = 1'($urandom_range(0, 3) == 0);
            exp_valid = 1'b0;
            brk(p, stop); if (stop) return;
            tick(); p++;
         end
         i_start = 1'b0; cnt = '0;
         for (int d = 0; d < dl; d++) begin
            i_hit = gen_hit(hm, p);
            if (i_hit && cnt != 16'hFFFF) cnt++;
            brk(p, stop); if (stop) return;
            tick(); p++;
         end
         exp_q.push_back('{sel: cur, cnt: cnt});
         exp_valid = 1'b1; nr = 0;
         do begin
            i_hit = gen_hit(hm, p); i_res_ready = gen_rdy(rm, nr); nr++;
            acc = i_res_ready;
            brk(p, stop); if (stop) return;
            tick(); p++;
         end while (!acc);
         i_res_ready = 1'b0; exp_valid = 1'b0;
         if (cur == last) begin
            exp_done = 1'b1;
            tick();
            exp_done = 1'b0; exp_busy = 1'b0;
            return;
         end
         cur = cur + 1; exp_sel = cur;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         i_hit = 1'($urandom_range(0, 1)); i_res_ready = 1'($urandom_range(0, 1));
         tick();
      end
      i_res_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] f, l;
      int n, k;
      vectors = 0; errors = 0; chk_en = 1'b0;
      ab_at = -1; rs_at = -1;
      i_rst = 1'b1; i_start = 0; i_abort = 0; i_hit = 0; i_res_ready = 0;
      i_first = '0; i_last = '0; i_dwell = '0;
      s_start = 0; s_hit = 0; s_ready = 0; s_first = '0; s_last = '0; s_dwell = '0;
      exp_busy = 0; exp_valid = 0; exp_done = 0; exp_sel = '0;
      #3;
      chk("init_sel", 64'(o_sel), 64'(0));
      chk("init_busy", 64'(o_busy), 64'(0));
      chk("init_res_cnt", 64'(o_res_cnt), 64'(0));
      tick(); tick();
      i_rst = 1'b0;
      chk_en = 1'b1;
      idle(2);

      run_sweep(32'h0000_FFFE, 32'h0000_FFFF, 16'd4, 1, 0, -1, -1, 1'b0);
      idle(2);
      run_sweep(32'h0000_FFFE, 32'h0000_FFFF, 16'd4, 1, 2, -1, -1, 1'b0);
      idle(2);
      run_sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 2, 0, -1, -1, 1'b0);
      idle(2);
      run_sweep(32'd5, 32'd3, 16'd4, 1, 0, -1, -1, 1'b0);
      idle(2);
      run_sweep(32'd10, 32'd12, 16'd3, 0, 0, 4, -1, 1'b0);
      idle(2);
      run_sweep(32'd20, 32'd22, 16'd3, 0, 0, 6, -1, 1'b1);
      idle(2);
      run_sweep(32'd30, 32'd32, 16'd3, 1, 0, -1, 6, 1'b0);
      idle(2);
      run_sweep(32'd1, 32'd3, 16'd2, 0, 1, -1, -1, 1'b0);
      idle(2);

      for (int r = 0; r < 12; r++) begin
         f = $urandom;
         if ($urandom_range(0, 3) == 0) f = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
         n = $urandom_range(0, 3);
         l = (f > 32'hFFFF_FFFF - 32'(n)) ? 32'hFFFF_FFFF : f + 32'(n);
         if ($urandom_range(0, 7) == 0 && f != 0) l = f - 1;
         run_sweep(f, l, 16'($urandom_range(0, 5)), 0, 1,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1,
                   -1, 1'($urandom_range(0, 1)));
         idle($urandom_range(1, 3));
      end

      // Narrow-counter instance: 10 hits into a 2-bit counter must saturate at 3.
      s_first = 8'd3; s_last = 8'd3; s_dwell = 8'd10; s_hit = 1'b1; s_ready = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      k = -1;
      for (int c = 1; c <= 40; c++) begin
         if (s_valid) begin
            k = c;
            break;
         end
         tick();
      end
      chk("sat_latency", 64'(k), 64'(12));
      chk("sat_cnt", 64'(s_res_cnt), 64'(3));
      chk("sat_sel", 64'(s_res_sel), 64'(3));
      tick();
      chk("sat_done", 64'(s_done), 64'(1));
      tick();
      chk("sat_idle", 64'(s_busy), 64'(0));

      idle(2);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
